// File: rtl/vm1_bus_watchdog_if.sv
// VM1 processor-side bus strobes, connector reply and synthetic reply,
// seen from the bus driver (master) and from the watchdog (slave).
interface vm1_bus_watchdog_if;
  logic nSYNC;
  logic nDIN;
  logic nDOUT;
  logic nMRPLY;
  logic nRPLY_FAKE;

  modport master (
    output nSYNC,
    output nDIN,
    output nDOUT,
    output nMRPLY,
    input  nRPLY_FAKE
  );

  modport slave (
    input  nSYNC,
    input  nDIN,
    input  nDOUT,
    input  nMRPLY,
    output nRPLY_FAKE
  );
endinterface

// File: rtl/vm1_bus_watchdog.sv
// VM1 bus-cycle supervisor: measures strobe-to-reply latency, flags cycles with
// no reply inside the timeout window and can complete them with a fake RPLY.
module vm1_bus_watchdog #(
  parameter int unsigned       TOUT_W   = 8,
  parameter logic [TOUT_W-1:0] TOUT_DEF = TOUT_W'(200),
  parameter int unsigned       SYNC_ST  = 2
) (
  input  logic              CLK,
  input  logic              nDCLO,
  vm1_bus_watchdog_if.slave bus,
  input  logic              FAKE_ENA,
  input  logic              TOUT_SEL,
  input  logic [TOUT_W-1:0] TOUT_VAL,
  input  logic              ERR_CLR,
  output logic              TOUT_ERR,
  output logic              TOUT_STB,
  output logic [TOUT_W-1:0] LAT,
  output logic              LAT_STB
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DONE = 3'd2,
    S_FAKE = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [TOUT_W-1:0]   cnt_q, cnt_d;
  logic [TOUT_W-1:0]   lim_q, lim_d;
  logic [TOUT_W-1:0]   lat_q, lat_d;
  logic [TOUT_W-1:0]   lim_raw;
  logic                fake_n_q, fake_n_d;
  logic                err_q, err_d;
  logic                tout_stb_q, tout_stb_d;
  logic                lat_stb_q, lat_stb_d;
  logic                sync_q, din_q, dout_q;
  logic [SYNC_ST-1:0]  rply_sq;
  logic                rply;
  logic                strb;

  // Strobes are CLK-synchronous: one register; the connector reply is not.
  always_ff @(posedge CLK or negedge nDCLO) begin
    if (!nDCLO) begin
      sync_q  <= 1'b1;
      din_q   <= 1'b1;
      dout_q  <= 1'b1;
      rply_sq <= '1;
    end else begin
      sync_q  <= bus.nSYNC;
      din_q   <= bus.nDIN;
      dout_q  <= bus.nDOUT;
      rply_sq <= {rply_sq[SYNC_ST-2:0], bus.nMRPLY};
    end
  end

  assign rply    = rply_sq[SYNC_ST-1];
  assign strb    = ~sync_q & (~din_q | ~dout_q);
  assign lim_raw = TOUT_SEL ? TOUT_VAL : TOUT_DEF;

  always_ff @(posedge CLK or negedge nDCLO) begin
    if (!nDCLO) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lim_q      <= TOUT_W'(1);
      lat_q      <= '0;
      fake_n_q   <= 1'b1;
      err_q      <= 1'b0;
      tout_stb_q <= 1'b0;
      lat_stb_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lim_q      <= lim_d;
      lat_q      <= lat_d;
      fake_n_q   <= fake_n_d;
      err_q      <= err_d;
      tout_stb_q <= tout_stb_d;
      lat_stb_q  <= lat_stb_d;
    end
  end

  // Reply beats timeout beats abort when they land in the same WAIT cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lim_d      = lim_q;
    lat_d      = lat_q;
    fake_n_d   = 1'b1;
    err_d      = err_q & ~ERR_CLR;
    tout_stb_d = 1'b0;
    lat_stb_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (strb) begin
          state_d = S_WAIT;
          cnt_d   = TOUT_W'(1);
          lim_d   = (lim_raw == '0) ? TOUT_W'(1) : lim_raw;
        end
      end
      S_WAIT: begin
        if (!rply) begin
          lat_d     = cnt_q;
          lat_stb_d = 1'b1;
          state_d   = S_DONE;
        end else if (cnt_q == lim_q) begin
          tout_stb_d = 1'b1;
          err_d      = 1'b1;
          if (FAKE_ENA) begin
            state_d  = S_FAKE;
            fake_n_d = 1'b0;
          end else begin
            state_d  = S_HOLD;
          end
        end else if (!strb) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + TOUT_W'(1);
        end
      end
      S_DONE: begin
        if (!strb && rply) state_d = S_IDLE;
      end
      S_FAKE: begin
        // Our own fake reply is never looked at; only the strobes end it.
        if (sync_q || (din_q && dout_q)) state_d = S_IDLE;
        else                             fake_n_d = 1'b0;
      end
      S_HOLD: begin
        if (!strb) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.nRPLY_FAKE = fake_n_q;
  assign TOUT_ERR       = err_q;
  assign TOUT_STB       = tout_stb_q;
  assign LAT            = lat_q;
  assign LAT_STB        = lat_stb_q;

endmodule
